// File: rtl/memwrite_tracer.sv
// Store-stream monitor for the data-memory write port. It logs accepted stores
// into a FIFO that a consumer can drain, and decides PASS/FAIL from the store pattern.
module memwrite_tracer #(
    parameter int            AW           = 32,
    parameter int            DW           = 32,
    parameter int            DEPTH        = 16,
    parameter int            PTR_W        = 4,
    parameter logic [AW-1:0] DONE_ADDR    = 84,
    parameter logic [DW-1:0] DONE_DATA    = 7,
    parameter logic [AW-1:0] SCRATCH_ADDR = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [AW-1:0]    dataadr,
    input  logic [DW-1:0]    writedata,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [AW-1:0]    rd_addr,
    output logic [DW-1:0]    rd_data,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic [1:0]       status,
    output logic             done,
    output logic [15:0]      store_cnt
);
    // state | meaning
    // RUN   | monitoring; stores are accepted and judged
    // PASS  | completion store seen; terminal until reset
    // FAIL  | illegal store seen; terminal until reset
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        PASS = 2'b01,
        FAIL = 2'b10
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW+DW-1:0]     mem [DEPTH];
    logic                 accept, full, empty, push, pop, drop;

    assign accept = memwrite && (state_q == RUN);
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign pop    = rd_en && !empty;
    // A full FIFO still takes the store when a pop frees a slot in the same edge.
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    assign status = state_q;
    assign done   = (state_q != RUN);

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (dataadr == DONE_ADDR && writedata == DONE_DATA)
                state_d = PASS;
            else if (dataadr != SCRATCH_ADDR)
                state_d = FAIL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            store_cnt <= '0;
        end else begin
            state_q  <= state_d;
            rd_valid <= pop;
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                {rd_addr, rd_data} <= mem[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            if (accept && store_cnt != 16'hFFFF)
                store_cnt <= store_cnt + 16'd1;
        end
    end

    // Storage is left unreset; only the pointers and count define valid contents.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= {dataadr, writedata};
    end

endmodule

// File: tb/tb_memwrite_tracer.sv
// Directed bench for memwrite_tracer: store logging, PASS/FAIL judgement,
// FIFO full/empty corner cases and asynchronous reset.
module tb_memwrite_tracer;
    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [1:0]  status;
    logic        done;
    logic [15:0] store_cnt;

    int tests = 0;
    int fails = 0;

    memwrite_tracer dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .rd_en     (rd_en),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .count     (count),
        .overflow  (overflow),
        .status    (status),
        .done      (done),
        .store_cnt (store_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic re);
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        rd_en     = re;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        memwrite = 1'b0;
        rd_en    = 1'b0;
        reset    = 1'b0;
        #2;
        reset    = 1'b1;
    endtask

    initial begin
        reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0; rd_en = 1'b0;
        #12;
        check("rst_status",   status,    2'b00);
        check("rst_done",     done,      1'b0);
        check("rst_count",    count,     5'd0);
        check("rst_overflow", overflow,  1'b0);
        check("rst_rd_valid", rd_valid,  1'b0);
        check("rst_store",    store_cnt, 16'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: scratch stores then completion store
        cyc(1, 80, 5, 0);
        cyc(1, 80, 6, 0);
        check("t1_status_run", status, 2'b00);
        cyc(1, 84, 7, 0);
        check("t1_status_pass", status,    2'b01);
        check("t1_done",        done,      1'b1);
        check("t1_count",       count,     5'd3);
        check("t1_store_cnt",   store_cnt, 16'd3);
        cyc(0, 0, 0, 1);
        check("t1_pop0_valid", rd_valid, 1'b1);
        check("t1_pop0_addr",  rd_addr,  32'd80);
        check("t1_pop0_data",  rd_data,  32'd5);
        cyc(0, 0, 0, 1);
        check("t1_pop1_addr",  rd_addr,  32'd80);
        check("t1_pop1_data",  rd_data,  32'd6);
        cyc(0, 0, 0, 1);
        check("t1_pop2_valid", rd_valid, 1'b1);
        check("t1_pop2_addr",  rd_addr,  32'd84);
        check("t1_pop2_data",  rd_data,  32'd7);
        cyc(0, 0, 0, 0);
        check("t1_idle_valid", rd_valid, 1'b0);
        check("t1_hold_data",  rd_data,  32'd7);
        check("t1_count_end",  count,    5'd0);

        // 2: wrong data at completion address fails; later stores ignored
        pulse_reset();
        cyc(1, 84, 9, 0);
        check("t2_status_fail", status,    2'b10);
        check("t2_done",        done,      1'b1);
        check("t2_store_cnt",   store_cnt, 16'd1);
        cyc(1, 84, 7, 0);
        check("t2_status_stay", status,    2'b10);
        check("t2_store_stay",  store_cnt, 16'd1);
        check("t2_count",       count,     5'd1);

        // 3: overflow after 17 stores
        pulse_reset();
        for (int i = 0; i < 16; i++) cyc(1, 80, 100 + i, 0);
        check("t3_count16",  count,    5'd16);
        check("t3_no_ovf16", overflow, 1'b0);
        cyc(1, 80, 116, 0);
        check("t3_count",     count,     5'd16);
        check("t3_overflow",  overflow,  1'b1);
        check("t3_store_cnt", store_cnt, 16'd17);
        check("t3_status",    status,    2'b00);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 1);
            check("t3_pop_valid", rd_valid, 1'b1);
            check("t3_pop_data",  rd_data,  100 + i);
        end
        cyc(0, 0, 0, 0);
        check("t3_drained",    count,    5'd0);
        check("t3_ovf_sticky", overflow, 1'b1);

        // 4: push and pop together while full
        pulse_reset();
        for (int i = 0; i < 16; i++) cyc(1, 80, 200 + i, 0);
        cyc(1, 80, 300, 1);
        check("t4_count",     count,     5'd16);
        check("t4_overflow",  overflow,  1'b0);
        check("t4_valid",     rd_valid,  1'b1);
        check("t4_oldest",    rd_data,   32'd200);
        check("t4_store_cnt", store_cnt, 16'd17);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 0, 0, 1);
            check("t4_pop_data", rd_data, 200 + i);
        end
        cyc(0, 0, 0, 1);
        check("t4_pop_last", rd_data, 32'd300);
        cyc(0, 0, 0, 0);
        check("t4_drained", count, 5'd0);

        // 5: empty FIFO corner cases
        pulse_reset();
        cyc(0, 0, 0, 1);
        check("t5_empty_valid", rd_valid, 1'b0);
        check("t5_empty_count", count,    5'd0);
        cyc(1, 80, 55, 1);
        check("t5_pp_count", count,    5'd1);
        check("t5_pp_valid", rd_valid, 1'b0);
        cyc(0, 0, 0, 1);
        check("t5_pop_valid", rd_valid, 1'b1);
        check("t5_pop_data",  rd_data,  32'd55);

        // 6: asynchronous reset mid-cycle
        pulse_reset();
        for (int i = 1; i <= 5; i++) cyc(1, 80, i, 0);
        cyc(1, 84, 7, 1);
        check("t6_pre_count",  count,    5'd5);
        check("t6_pre_status", status,   2'b01);
        check("t6_pre_valid",  rd_valid, 1'b1);
        memwrite = 1'b0; rd_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_count",    count,     5'd0);
        check("t6_status",   status,    2'b00);
        check("t6_done",     done,      1'b0);
        check("t6_valid",    rd_valid,  1'b0);
        check("t6_rd_data",  rd_data,   32'd0);
        check("t6_rd_addr",  rd_addr,   32'd0);
        check("t6_store",    store_cnt, 16'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
